// File: rtl/cache_controller_if.sv
// Pipeline, cache and SRAM signals of the data-cache controller.
// master = controller side, slave = environment (pipeline, cache arrays, SRAM controller).
interface cache_controller_if #(
   parameter int CACHE_ADDR_W = 17
);
   // Handshake: a pipeline request (mem_r_en/mem_w_en) completes in the cycle
   // mem_ready=1 and the pipeline holds mem_* stable until then; sram_r_en or
   // sram_w_en stays high until the single-cycle sram_ready pulse.
   logic                    mem_r_en;
   logic                    mem_w_en;
   logic [31:0]             mem_addr;
   logic [31:0]             mem_wdata;
   logic [31:0]             mem_rdata;
   logic                    mem_ready;

   logic [CACHE_ADDR_W-1:0] cache_address;
   logic [63:0]             cache_write_data;
   logic                    cache_read_en;
   logic                    cache_write_en;
   logic                    cache_invoke_set_en;
   logic [31:0]             cache_read_data;
   logic                    cache_hit;

   logic [31:0]             sram_address;
   logic [31:0]             sram_wdata;
   logic                    sram_r_en;
   logic                    sram_w_en;
   logic [63:0]             sram_rdata;
   logic                    sram_ready;

   logic [31:0]             stat_hits;
   logic [31:0]             stat_misses;
   logic [1:0]              dbg_state;

   modport master (
      input  mem_r_en, mem_w_en, mem_addr, mem_wdata,
      output mem_rdata, mem_ready,
      output cache_address, cache_write_data, cache_read_en, cache_write_en, cache_invoke_set_en,
      input  cache_read_data, cache_hit,
      output sram_address, sram_wdata, sram_r_en, sram_w_en,
      input  sram_rdata, sram_ready,
      output stat_hits, stat_misses, dbg_state
   );

   modport slave (
      output mem_r_en, mem_w_en, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready,
      input  cache_address, cache_write_data, cache_read_en, cache_write_en, cache_invoke_set_en,
      output cache_read_data, cache_hit,
      input  sram_address, sram_wdata, sram_r_en, sram_w_en,
      output sram_rdata, sram_ready,
      input  stat_hits, stat_misses, dbg_state
   );
endinterface

// File: rtl/cache_controller.sv
// Write-through, no-write-allocate initiator for the 2-way data cache; fills 64-bit lines on read miss.
// Optional hit/miss counters are built when CACHE_CTRL_STATS_EN is defined.
module cache_controller #(
   parameter int BASE_ADDR    = 1024,
   parameter int CACHE_ADDR_W = 17
) (
   input logic              clk,
   input logic              rst,
   cache_controller_if.master bus
);
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_MISS  = 2'd1;
   localparam logic [1:0] ST_FILL  = 2'd2;
   localparam logic [1:0] ST_WRITE = 2'd3;

   localparam logic [31:0] BASE = 32'(BASE_ADDR);

   logic [1:0]  state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [63:0] line_q, line_d;

   function automatic logic [CACHE_ADDR_W-1:0] cache_word(input logic [31:0] a);
      return CACHE_ADDR_W'((a - BASE) >> 2);
   endfunction

   // Line base is aligned relative to BASE, not to absolute address zero.
   function automatic logic [31:0] line_addr(input logic [31:0] a);
      return ((a - BASE) & ~32'h7) + BASE;
   endfunction

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      line_d  = line_q;

      bus.mem_ready           = 1'b1;
      bus.mem_rdata           = '0;
      bus.cache_address       = cache_word(addr_q);
      bus.cache_write_data    = '0;
      bus.cache_read_en       = 1'b0;
      bus.cache_write_en      = 1'b0;
      bus.cache_invoke_set_en = 1'b0;
      bus.sram_address        = '0;
      bus.sram_wdata          = '0;
      bus.sram_r_en           = 1'b0;
      bus.sram_w_en           = 1'b0;

      case (state_q)
         ST_IDLE: begin
            bus.cache_address = cache_word(bus.mem_addr);
            if (bus.mem_w_en) begin
               bus.cache_invoke_set_en = 1'b1;
               bus.mem_ready           = 1'b0;
               addr_d                  = bus.mem_addr;
               wdata_d                 = bus.mem_wdata;
               state_d                 = ST_WRITE;
            end else if (bus.mem_r_en) begin
               if (bus.cache_hit) begin
                  bus.cache_read_en = 1'b1;
                  bus.mem_rdata     = bus.cache_read_data;
               end else begin
                  bus.mem_ready = 1'b0;
                  addr_d        = bus.mem_addr;
                  state_d       = ST_MISS;
               end
            end
         end
         ST_MISS: begin
            bus.mem_ready    = 1'b0;
            bus.sram_r_en    = 1'b1;
            bus.sram_address = line_addr(addr_q);
            if (bus.sram_ready) begin
               line_d  = bus.sram_rdata;
               state_d = ST_FILL;
            end
         end
         ST_FILL: begin
            bus.cache_write_en   = 1'b1;
            bus.cache_write_data = line_q;
            bus.mem_rdata        = 1'((addr_q - BASE) >> 2) ? line_q[63:32] : line_q[31:0];
            state_d              = ST_IDLE;
         end
         ST_WRITE: begin
            bus.sram_w_en    = 1'b1;
            bus.sram_address = addr_q;
            bus.sram_wdata   = wdata_q;
            bus.mem_ready    = bus.sram_ready;
            if (bus.sram_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         line_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         line_q  <= line_d;
      end
   end

   assign bus.dbg_state = state_q;

`ifdef CACHE_CTRL_STATS_EN
   logic [31:0] stat_hits_q, stat_hits_d;
   logic [31:0] stat_misses_q, stat_misses_d;

   always_comb begin
      stat_hits_d   = stat_hits_q;
      stat_misses_d = stat_misses_q;
      if (state_q == ST_IDLE && bus.mem_r_en && !bus.mem_w_en) begin
         if (bus.cache_hit) stat_hits_d   = stat_hits_q + 32'd1;
         else               stat_misses_d = stat_misses_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_hits_q   <= '0;
         stat_misses_q <= '0;
      end else begin
         stat_hits_q   <= stat_hits_d;
         stat_misses_q <= stat_misses_d;
      end
   end

   assign bus.stat_hits   = stat_hits_q;
   assign bus.stat_misses = stat_misses_q;
`else
   assign bus.stat_hits   = '0;
   assign bus.stat_misses = '0;
`endif
endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Initiator side of the 2-way data cache interface. Sits between the MEM stage and the SRAM controller.
- Accepts 32-bit word reads and writes from the pipeline and drives the cache's read_en/write_en/invoke_set_en/address/write_data.
- Fetches 64-bit lines from the SRAM controller on read misses.
- Writes go through to SRAM; the cached copy is invalidated (write-through, no-write-allocate).

Parameters:
- BASE_ADDR, 1024, byte address of data memory word 0; subtracted before all mapping.
- CACHE_ADDR_W, 17, width of cache word address (tag 10, index 6, offset 1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mem_r_en  in  1  pipeline read request
- mem_w_en  in  1  pipeline write request
- mem_addr  in  32  byte address, word aligned
- mem_wdata  in  32  write data
- mem_rdata  out  32  read data, valid when mem_ready=1 on a read
- mem_ready  out  1  request complete; pipeline freezes while 0
- cache_address  out  CACHE_ADDR_W  cache word address
- cache_write_data  out  64  line to fill, {odd word, even word}
- cache_read_en  out  1  cache LRU update strobe
- cache_write_en  out  1  cache line fill strobe
- cache_invoke_set_en  out  1  invalidate hit way
- cache_read_data  in  32  cache word (combinational)
- cache_hit  in  1  cache hit (combinational)
- sram_address  out  32  SRAM byte address
- sram_wdata  out  32  SRAM write word
- sram_r_en  out  1  SRAM 64-bit line read request
- sram_w_en  out  1  SRAM 32-bit write request
- sram_rdata  in  64  SRAM line, valid with sram_ready
- sram_ready  in  1  one-cycle completion pulse
- stat_hits  out  32  read-hit count (see Optional Feature)
- stat_misses  out  32  read-miss count (see Optional Feature)

Behaviour:
- Address map:
  - word = (mem_addr - BASE_ADDR) >> 2.
  - cache_address = word[16:0]; offset = word[0].
  - Line SRAM address = (mem_addr - BASE_ADDR) with bits [2:0] cleared, plus BASE_ADDR.
- States: IDLE, MISS, FILL, WRITE. Reset (sync, rst=1 at posedge) → IDLE from any state, including mid-miss or mid-write. All SRAM/cache strobes deassert in the cycle after reset.
- Reset/idle output values:
  - mem_ready=1, mem_rdata=0.
  - All cache and SRAM enables 0; sram_address, sram_wdata, cache_write_data = 0.
  - stat counters 0.
- IDLE, no request: mem_ready=1, all enables 0.
- IDLE, mem_r_en=1 and cache_hit=1:
  - Combinational: mem_rdata=cache_read_data, mem_ready=1, cache_read_en=1. Zero-cycle latency.
  - Stay in IDLE.
- IDLE, mem_r_en=1 and cache_hit=0: mem_ready=0; next state MISS.
- MISS:
  - sram_r_en=1, sram_address=line address, mem_ready=0.
  - Hold until sram_ready=1, then latch sram_rdata into a 64-bit line register → FILL.
- FILL (exactly 1 cycle):
  - cache_write_en=1, cache_write_data=line register, mem_ready=1.
  - mem_rdata = offset ? line[63:32] : line[31:0].
  - → IDLE.
  - Next-cycle same-address read hits.
- IDLE, mem_w_en=1:
  - cache_invoke_set_en=1 for that single cycle; the cache acts only if cache_hit.
  - mem_ready=0 → WRITE.
- WRITE:
  - sram_w_en=1, sram_address=mem_addr, sram_wdata=mem_wdata, mem_ready=0.
  - On sram_ready=1: mem_ready=1 combinationally that cycle → IDLE.
- mem_r_en and mem_w_en both 1: treated as write; read ignored.
- Pipeline holds mem_* stable while mem_ready=0. Request changes mid-MISS/WRITE are ignored; the latched address is used.
- sram_ready seen in IDLE or FILL is ignored.
- cache_read_en is never asserted together with cache_write_en or cache_invoke_set_en.

Optional Feature:
- Macro: CACHE_CTRL_STATS_EN.
- Defined:
  - stat_hits increments on each IDLE read-hit cycle.
  - stat_misses increments on each IDLE→MISS transition.
  - Both wrap at 2^32 and are cleared by rst.
- Undefined: stat_hits and stat_misses are tied to 0 and no counter logic is built.

Test Plan:
- Read miss then hit:
  - Stimulus: read 0x408 (word 2, offset 0), cache_hit=0; SRAM returns {32'hBBBB, 32'hAAAA} after 3 cycles.
  - Required: sram_r_en held with sram_address=0x408; FILL cycle has cache_write_en=1, mem_rdata=32'hAAAA, mem_ready=1.
  - Follow-up read 0x40C with cache_hit=1, cache_read_data=32'hBBBB gives mem_ready=1 same cycle.
- Odd-offset miss: read 0x40C miss, line {32'h2, 32'h1} → FILL mem_rdata=32'h2; sram_address=0x408.
- Write hit:
  - Stimulus: write 0x500 data 0x55, cache_hit=1.
  - Required: one-cycle cache_invoke_set_en=1; WRITE drives sram_w_en, sram_address=0x500, sram_wdata=0x55; mem_ready=0 until sram_ready, then 1.
- Simultaneous r_en+w_en on 0x400: write path only; sram_r_en never asserted.
- Reset mid-MISS: assert rst in cycle 2 of MISS → next cycle IDLE, sram_r_en=0, mem_ready=1; a late sram_ready causes no cache_write_en.
- Stats (macro defined): 2 misses + 3 hits → stat_misses=2, stat_hits=3; rst → both 0; macro undefined → both always 0.
